// File: rtl/scoot_pkg.sv
// Shared types and helpers for the scoot grid-world controller.
package scoot_pkg;

  // Legacy-compatible state codes; the enum below is built on them.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PICK   = 3'd1;
  localparam logic [2:0] ST_SENSE  = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_MOVE   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    PICK   = ST_PICK,
    SENSE  = ST_SENSE,
    SETTLE = ST_SETTLE,
    MOVE   = ST_MOVE,
    DONE   = ST_DONE
  } stateT;

  // Bit positions of the sensor and move vectors.
  localparam int UP    = 0;
  localparam int RIGHT = 1;
  localparam int DOWN  = 2;
  localparam int LEFT  = 3;

  // Toroidal step on an axis of size m; explicit compare, no power-of-two assumption.
  function automatic int wrapInc(input int v, input int m);
    return (v == m - 1) ? 0 : v + 1;
  endfunction

  function automatic int wrapDec(input int v, input int m);
    return (v == 0) ? m - 1 : v - 1;
  endfunction

endpackage

// File: rtl/scoot_neighbour_sel.sv
// Combinational extraction of the four cells around the bot, with toroidal wrap.
module scoot_neighbour_sel
  import scoot_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int HEIGHT = 10,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT)
) (
  input  logic [WIDTH-1:0][HEIGHT-1:0] grid,
  input  logic [XW-1:0]                posX,
  input  logic [YW-1:0]                posY,
  output logic [3:0]                   nbr
);

  logic [XW-1:0] xInc, xDec;
  logic [YW-1:0] yInc, yDec;

  // Wrapped neighbour coordinates and the pellet bits found there.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    nbr  = '0;
    xInc = XW'(wrapInc(int'(posX), WIDTH));
    xDec = XW'(wrapDec(int'(posX), WIDTH));
    yInc = YW'(wrapInc(int'(posY), HEIGHT));
    yDec = YW'(wrapDec(int'(posY), HEIGHT));
    nbr[UP]    = grid[posX][yInc];
    nbr[RIGHT] = grid[xInc][posY];
    nbr[DOWN]  = grid[posX][yDec];
    nbr[LEFT]  = grid[xDec][posY];
  end

endmodule

// File: rtl/scoot_world_ctrl.sv
// Grid-world sequencer: holds the pellet map and bot position, drives the bot's
// light sensors, applies its moves with wrap, and collects pellets.
module scoot_world_ctrl
  import scoot_pkg::*;
#(
  parameter int WIDTH       = 10,
  parameter int HEIGHT      = 10,
  parameter int BOT_LATENCY = 1,
  parameter int STEP_W      = 16,
  parameter int SCORE_W     = 16,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load_en,
  input  logic [XW-1:0]      load_col,
  input  logic [HEIGHT-1:0]  load_data,
  input  logic               start,
  input  logic [STEP_W-1:0]  num_steps,
  output logic               l_up,
  output logic               l_right,
  output logic               l_down,
  output logic               l_left,
  input  logic               m_up,
  input  logic               m_right,
  input  logic               m_down,
  input  logic               m_left,
  output logic [XW-1:0]      pos_x,
  output logic [YW-1:0]      pos_y,
  output logic [SCORE_W-1:0] score,
  output logic [STEP_W-1:0]  steps_done,
  output logic               busy,
  output logic               done
);

  localparam int            LW      = (BOT_LATENCY > 1) ? $clog2(BOT_LATENCY) : 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(BOT_LATENCY - 1);
  localparam logic [XW-1:0] X_HOME  = XW'(WIDTH / 2);
  localparam logic [YW-1:0] Y_HOME  = YW'(HEIGHT / 2);

  stateT                         state;
  logic [WIDTH-1:0][HEIGHT-1:0]  grid;
  logic [XW-1:0]                 posX, nextX;
  logic [YW-1:0]                 posY, nextY;
  logic [SCORE_W-1:0]            scoreR;
  logic [STEP_W-1:0]             stepsR, limit;
  logic [3:0]                    light, nbr;
  logic [LW-1:0]                 settleCnt;
  logic                          busyR, doneR;
  logic                          hit, idleLike;
  logic                          wrEn;
  logic [XW-1:0]                 wrCol;
  logic [HEIGHT-1:0]             wrData;

  assign idleLike = (state == IDLE) || (state == DONE);
  assign hit      = grid[posX][posY];

  scoot_neighbour_sel #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) uNbr (
    .grid (grid),
    .posX (posX),
    .posY (posY),
    .nbr  (nbr)
  );

  // Single grid write port: host column load when idle, pellet clear in PICK.
  always_comb begin
    wrEn   = 1'b0;
    wrCol  = posX;
    wrData = grid[posX];
    if (idleLike && load_en && (int'(load_col) < WIDTH)) begin
      wrEn   = 1'b1;
      wrCol  = load_col;
      wrData = load_data;
    end else if ((state == PICK) && hit) begin
      wrEn         = 1'b1;
      wrData[posY] = 1'b0;
    end
  end

  // Next position from the sampled move request; opposing pairs cancel per axis.
  always_comb begin
    nextX = posX;
    nextY = posY;
    if (m_right && !m_left)      nextX = XW'(wrapInc(int'(posX), WIDTH));
    else if (m_left && !m_right) nextX = XW'(wrapDec(int'(posX), WIDTH));
    if (m_up && !m_down)         nextY = YW'(wrapInc(int'(posY), HEIGHT));
    else if (m_down && !m_up)    nextY = YW'(wrapDec(int'(posY), HEIGHT));
  end

  // Pellet map storage.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the grid is reset explicitly because an empty map after reset is part of the block's contract, so it cannot be left as an unreset RAM.
    if (!reset_n)  grid        <= '0;
    else if (wrEn) grid[wrCol] <= wrData;
  end

  // Run sequencer: start, pickup, sensor drive, settle wait, move.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      posX      <= X_HOME;
      posY      <= Y_HOME;
      scoreR    <= '0;
      stepsR    <= '0;
      limit     <= '0;
      light     <= '0;
      settleCnt <= '0;
      busyR     <= 1'b0;
      doneR     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            posX   <= X_HOME;
            posY   <= Y_HOME;
            scoreR <= '0;
            stepsR <= '0;
            limit  <= num_steps;
            doneR  <= 1'b0;
            busyR  <= 1'b1;
            state  <= PICK;
          end
        end
        PICK: begin
          if (hit && (scoreR != '1)) scoreR <= scoreR + SCORE_W'(1);
          if (stepsR == limit) begin
            busyR <= 1'b0;
            doneR <= 1'b1;
            state <= DONE;
          end else begin
            state <= SENSE;
          end
        end
        SENSE: begin
          light     <= nbr;
          settleCnt <= '0;
          state     <= SETTLE;
        end
        SETTLE: begin
          if (settleCnt == LAT_LAST) state     <= MOVE;
          else                       settleCnt <= settleCnt + LW'(1);
        end
        MOVE: begin
          posX   <= nextX;
          posY   <= nextY;
          stepsR <= stepsR + STEP_W'(1);
          light  <= '0;
          state  <= PICK;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign l_up       = light[UP];
  assign l_right    = light[RIGHT];
  assign l_down     = light[DOWN];
  assign l_left     = light[LEFT];
  assign pos_x      = posX;
  assign pos_y      = posY;
  assign score      = scoreR;
  assign steps_done = stepsR;
  assign busy       = busyR;
  assign done       = doneR;

endmodule

// File: tb/tb_scoot_world_ctrl.sv
// Bench for scoot_world_ctrl: a table-driven bot reacts to the sensors, a
// reference model predicts each run's result, a monitor checks at each done.
module tb_scoot_world_ctrl;

  localparam int W   = 10;
  localparam int H   = 10;
  localparam int LAT = 1;
  localparam int SW  = 16;
  localparam int CW  = 16;
  localparam int XW  = $clog2(W);
  localparam int YW  = $clog2(H);

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          load_en = 1'b0;
  logic [XW-1:0] load_col = '0;
  logic [H-1:0]  load_data = '0;
  logic          start = 1'b0;
  logic [SW-1:0] num_steps = '0;
  logic          l_up, l_right, l_down, l_left;
  logic          m_up = 1'b0, m_right = 1'b0, m_down = 1'b0, m_left = 1'b0;
  logic [XW-1:0] pos_x;
  logic [YW-1:0] pos_y;
  logic [CW-1:0] score;
  logic [SW-1:0] steps_done;
  logic          busy, done;

  always #5 clock = ~clock;

  scoot_world_ctrl #(
    .WIDTH (W), .HEIGHT (H), .BOT_LATENCY (LAT), .STEP_W (SW), .SCORE_W (CW)
  ) dut (
    .clock (clock), .reset_n (reset_n),
    .load_en (load_en), .load_col (load_col), .load_data (load_data),
    .start (start), .num_steps (num_steps),
    .l_up (l_up), .l_right (l_right), .l_down (l_down), .l_left (l_left),
    .m_up (m_up), .m_right (m_right), .m_down (m_down), .m_left (m_left),
    .pos_x (pos_x), .pos_y (pos_y), .score (score), .steps_done (steps_done),
    .busy (busy), .done (done)
  );

  typedef struct {
    int px;
    int py;
    int score;
    int steps;
    int cycles;
  } expT;

  int         errors = 0;
  int         checks = 0;
  expT        sbq[$];
  bit         mgrid[W][H];
  logic [3:0] policy[16];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference run: vectors are {left,down,right,up}; positions wrap with modulo arithmetic.
  function automatic expT modelRun(input int n);
    int px = W / 2;
    int py = H / 2;
    int sc = 0;
    int st = 0;
    logic [3:0] s, mv;
    expT e;
    while (1) begin
      if (mgrid[px][py]) begin
        mgrid[px][py] = 1'b0;
        sc++;
      end
      if (st == n) break;
      s[0] = mgrid[px][(py + 1) % H];
      s[1] = mgrid[(px + 1) % W][py];
      s[2] = mgrid[px][(py + H - 1) % H];
      s[3] = mgrid[(px + W - 1) % W][py];
      mv = policy[s];
      px = (px + int'(mv[1]) - int'(mv[3]) + W) % W;
      py = (py + int'(mv[0]) - int'(mv[2]) + H) % H;
      st++;
    end
    e.px     = px;
    e.py     = py;
    e.score  = sc;
    e.steps  = n;
    e.cycles = n * (3 + LAT) + 1;
    return e;
  endfunction

  // Bot stand-in: after each edge, present the move its table gives for the current sensors.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      {m_left, m_down, m_right, m_up} = policy[{l_left, l_down, l_right, l_up}];
    end
  end

  // Monitor: on each rising done, compare the run result against the oldest prediction.
  initial begin
    bit  prevDone;
    int  busyCycles;
    expT e;
    prevDone   = 1'b0;
    busyCycles = 0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        prevDone   = 1'b0;
        busyCycles = 0;
      end else begin
        if (busy) busyCycles++;
        if (done && !prevDone) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done with no run pending, expected none");
          end else begin
            e = sbq.pop_front();
            check("run_pos_x", int'(pos_x), e.px);
            check("run_pos_y", int'(pos_y), e.py);
            check("run_score", int'(score), e.score);
            check("run_steps", int'(steps_done), e.steps);
            check("run_busy_cycles", busyCycles, e.cycles);
            check("run_busy_low", int'(busy), 0);
          end
          busyCycles = 0;
        end
        prevDone = done;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic setPolicy(input logic [3:0] mv);
    for (int i = 0; i < 16; i++) policy[i] = mv;
  endtask

  task automatic loadCol(input int col, input logic [H-1:0] data);
    load_en   = 1'b1;
    load_col  = XW'(col);
    load_data = data;
    tick();
    load_en = 1'b0;
    if (col < W) for (int y = 0; y < H; y++) mgrid[col][y] = data[y];
  endtask

  task automatic runStart(input int n, input bit push, input bit ld, input int col,
                          input logic [H-1:0] data);
    if (ld && col < W) for (int y = 0; y < H; y++) mgrid[col][y] = data[y];
    if (push) sbq.push_back(modelRun(n));
    num_steps = SW'(n);
    start     = 1'b1;
    load_en   = ld;
    load_col  = XW'(col);
    load_data = data;
    tick();
    start   = 1'b0;
    load_en = 1'b0;
  endtask

  task automatic waitDone(input int n);
    for (int i = 0; i < n * (3 + LAT) + 10 && !done; i++) tick();
    check("run_done", int'(done), 1);
    tick();
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_pos_x"}, int'(pos_x), W / 2);
    check({tag, "_pos_y"}, int'(pos_y), H / 2);
    check({tag, "_score"}, int'(score), 0);
    check({tag, "_steps"}, int'(steps_done), 0);
    check({tag, "_lights"}, int'({l_left, l_down, l_right, l_up}), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    int nl, n;
    bit ld;
    setPolicy(4'b0000);
    for (int x = 0; x < W; x++) for (int y = 0; y < H; y++) mgrid[x][y] = 1'b0;

    // Power-up reset state.
    tick();
    tick();
    checkResetOutputs("reset");
    reset_n = 1'b1;
    tick();

    // Lone pellet at the centre, zero steps; a repeat run finds it gone.
    loadCol(5, H'(1 << 5));
    runStart(0, 1'b1, 1'b0, 0, '0);
    waitDone(0);
    runStart(0, 1'b1, 1'b0, 0, '0);
    waitDone(0);

    // Left+down held: walks to the corner and wraps to (9,9).
    setPolicy(4'b1100);
    runStart(6, 1'b1, 1'b0, 0, '0);
    waitDone(6);

    // Up and down cancel, right moves one column.
    setPolicy(4'b0111);
    runStart(1, 1'b1, 1'b0, 0, '0);
    waitDone(1);

    // Full column, bot runs up 12 steps and revisits emptied cells.
    setPolicy(4'b0001);
    loadCol(5, '1);
    runStart(12, 1'b1, 1'b0, 0, '0);
    waitDone(12);

    // start/load_en during SENSE are ignored.
    runStart(12, 1'b1, 1'b0, 0, '0);
    tick();
    num_steps = SW'(3);
    start     = 1'b1;
    load_en   = 1'b1;
    load_col  = XW'(5);
    load_data = '1;
    tick();
    start   = 1'b0;
    load_en = 1'b0;
    check("sense_ignore_busy", int'(busy), 1);
    waitDone(12);

    // Reset asserted while sensors are held in SETTLE.
    setPolicy(4'b0000);
    loadCol(4, '1);
    loadCol(5, '1);
    loadCol(6, '1);
    runStart(5, 1'b0, 1'b0, 0, '0);
    tick();
    tick();
    check("settle_lights", int'({l_left, l_down, l_right, l_up}), 15);
    reset_n = 1'b0;
    #1;
    checkResetOutputs("midrun_reset");
    for (int x = 0; x < W; x++) for (int y = 0; y < H; y++) mgrid[x][y] = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    setPolicy(4'b0001);
    runStart(10, 1'b1, 1'b0, 0, '0);
    waitDone(10);
    setPolicy(4'b0010);
    runStart(10, 1'b1, 1'b0, 0, '0);
    waitDone(10);

    // Randomised maps, bot tables and run lengths; some loads coincide with start.
    for (int r = 0; r < 25; r++) begin
      nl = $urandom_range(0, 4);
      for (int k = 0; k < nl; k++) loadCol($urandom_range(0, 15), H'($urandom));
      for (int i = 0; i < 16; i++) policy[i] = 4'($urandom_range(0, 15));
      n  = $urandom_range(0, 20);
      ld = ($urandom_range(0, 2) == 0);
      runStart(n, 1'b1, ld, $urandom_range(0, 15), H'($urandom));
      waitDone(n);
    end

    check("scoreboard_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
